change_dispenser: RTL and testbench
===================================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- INIT_NICKELS, 10, nickel inventory after reset (0..15).
- INIT_DIMES, 10, dime inventory after reset (0..15).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high.
- Dispense  in  1  vend request strobe from the coin-acceptor FSM.
- ReturnNickel  in  1  5c change owed; sampled with Dispense.
- ReturnDime  in  1  10c change owed; sampled with Dispense.
- ReturnTwoDimes  in  1  20c change owed; sampled with Dispense.
- MechDone  in  1  ejector mechanism acknowledge.
- LoadNickel  in  1  refill strobe: +1 nickel per cycle high.
- LoadDime  in  1  refill strobe: +1 dime per cycle high.
- EjectProduct  out  1  product ejector drive.
- EjectNickel  out  1  nickel ejector drive.
- EjectDime  out  1  dime ejector drive.
- Busy  out  1  high in every state except IDLE.
- Overrun  out  1  one-cycle pulse: Dispense dropped while busy.
- ChangeError  out  1  sticky: change could not be paid in full.
- Shortfall  out  3  unpaid change in nickel units at last error.
- NickelCount  out  4  current nickel inventory.
- DimeCount  out  4  current dime inventory.

Function
REQ-003 Owed change SHALL be held in nickel units, 3 bits: ReturnNickel*1 + ReturnDime*2 + ReturnTwoDimes*4; range 0..7.
REQ-004 FSM states SHALL be IDLE, VEND, SELECT, COIN, GAP.
REQ-005 IDLE: Dispense=1 at an edge -> load owed, go to VEND. Return inputs without Dispense -> ignored.
REQ-006 VEND: EjectProduct=1 continuously; MechDone=1 at an edge -> SELECT. EjectProduct is low from the next cycle.
REQ-007 SELECT is one cycle with all ejects low.
- owed=0 -> IDLE.
- owed>=2 and DimeCount>0 -> COIN with dime selected.
- Otherwise, NickelCount>0 -> COIN with nickel selected.
- Otherwise -> ChangeError=1, Shortfall=owed, IDLE.
REQ-008 COIN: exactly the selected eject line is high until MechDone=1 at an edge. On that edge:
- selected inventory -1;
- owed -1 (nickel) or -2 (dime);
- state -> GAP.
REQ-009 GAP SHALL last one cycle with all ejects low, MechDone ignored, then -> SELECT.
REQ-010 The dime-first greedy rule SHALL make a dime shortage fall back to nickels: 10c with 0 dimes pays two nickels.
REQ-011 At most one Eject* output SHALL be high in any cycle.
REQ-012 Dispense=1 while Busy=1 SHALL be dropped and pulse Overrun for one cycle; the transaction in progress is unaffected.
REQ-013 MechDone in IDLE, SELECT or GAP SHALL have no effect.
REQ-014 Refill: each cycle, LoadNickel/LoadDime add 1 to the matching count, saturating at 15. A load and a decrement on the same edge SHALL leave the count unchanged.
REQ-015 ChangeError SHALL stay set until reset; a later error SHALL overwrite Shortfall.
REQ-016 Latency: Dispense sampled at edge t SHALL raise EjectProduct in the cycle after t, with Busy high from that cycle.

Reset
REQ-017 While reset=1, and immediately on its assertion, the block SHALL set:
- state=IDLE;
- all Eject* = 0; Busy=0; Overrun=0; ChangeError=0; Shortfall=0;
- NickelCount=INIT_NICKELS; DimeCount=INIT_DIMES.
REQ-018 Reset mid-transaction SHALL abandon the owed change without decrementing inventory or flagging an error.

Verification
REQ-019 Dispense only, MechDone 2 cycles later:
- EjectProduct high for 3 cycles, then IDLE;
- counts 10/10; no coin ejects.
REQ-020 Dispense+ReturnNickel+ReturnDime (15c), defaults:
- sequence Product, Dime, Nickel, with a one-cycle gap before the nickel;
- final counts N=9, D=9.
REQ-021 DimeCount=0, Dispense+ReturnTwoDimes:
- four EjectNickel handshakes;
- NickelCount 10 -> 6; ChangeError=0.
REQ-022 Counts N=1, D=0, Dispense+ReturnDime:
- one nickel ejected;
- ChangeError=1, Shortfall=1, NickelCount=0.
REQ-023 Dispense pulsed during VEND:
- Overrun high for exactly 1 cycle;
- only one product ejected.
REQ-024 Reset asserted during COIN (dime):
- EjectDime drops asynchronously;
- counts return to 10/10; Busy=0.

Source files
------------

// File: rtl/change_dispenser.sv
// change_dispenser
//   Pays out a vended product and then any change owed, one ejector at a time.
//   Change is paid greedily: a dime is used while at least 10c is owed and a
//   dime is in stock, otherwise a nickel. If neither coin can cover what is
//   still owed, the remainder is reported and the transaction ends.
//
// Handshakes:
//   Dispense is a single-cycle request. It is accepted only in IDLE, and the
//   Return* inputs are captured on the same edge. While Busy is high, a
//   Dispense is dropped and Overrun pulses for one cycle. Each Eject* line is
//   held high until MechDone is seen high on a rising edge. That edge completes
//   the ejection. MechDone has no effect while no Eject* line is high.
//
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   Dispense        vend request strobe
//   ReturnNickel    5c owed   (sampled with Dispense)
//   ReturnDime      10c owed  (sampled with Dispense)
//   ReturnTwoDimes  20c owed  (sampled with Dispense)
//   MechDone        ejector acknowledge
//   LoadNickel      +1 nickel per cycle high (saturates at 15)
//   LoadDime        +1 dime per cycle high (saturates at 15)
//   EjectProduct    product ejector drive
//   EjectNickel     nickel ejector drive
//   EjectDime       dime ejector drive
//   Busy            high whenever the FSM is not in IDLE
//   Overrun         one-cycle pulse: a Dispense was dropped while busy
//   ChangeError     sticky until reset: change could not be paid in full
//   Shortfall       unpaid change, in nickel units, at the most recent error
//   NickelCount     nickel inventory
//   DimeCount       dime inventory
module change_dispenser #(
  parameter int unsigned INIT_NICKELS = 10,
  parameter int unsigned INIT_DIMES   = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Dispense,
  input  logic       ReturnNickel,
  input  logic       ReturnDime,
  input  logic       ReturnTwoDimes,
  input  logic       MechDone,
  input  logic       LoadNickel,
  input  logic       LoadDime,
  output logic       EjectProduct,
  output logic       EjectNickel,
  output logic       EjectDime,
  output logic       Busy,
  output logic       Overrun,
  output logic       ChangeError,
  output logic [2:0] Shortfall,
  output logic [3:0] NickelCount,
  output logic [3:0] DimeCount
);

  typedef enum logic [2:0] {IDLE, VEND, SELECT, COIN, GAP} state_t;

  localparam logic [3:0] INIT_N = INIT_NICKELS[3:0];
  localparam logic [3:0] INIT_D = INIT_DIMES[3:0];

  state_t     state, state_nx;
  logic [2:0] owed, owed_nx;       // change still owed, in nickel units
  logic       sel_dime, sel_dime_nx;
  logic       err_set;             // SELECT found no coin able to pay
  logic       coin_take;           // COIN ejection acknowledged this edge
  logic       nick_dec, dime_dec;

  assign Busy     = (state != IDLE);
  assign nick_dec = coin_take & ~sel_dime;
  assign dime_dec = coin_take &  sel_dime;

  always_comb begin
    state_nx     = state;
    owed_nx      = owed;
    sel_dime_nx  = sel_dime;
    err_set      = 1'b0;
    coin_take    = 1'b0;
    EjectProduct = 1'b0;
    EjectNickel  = 1'b0;
    EjectDime    = 1'b0;
    case (state)
      IDLE: begin
        if (Dispense) begin
          owed_nx  = {ReturnTwoDimes, ReturnDime, ReturnNickel};
          state_nx = VEND;
        end
      end
      VEND: begin
        EjectProduct = 1'b1;
        if (MechDone) state_nx = SELECT;
      end
      SELECT: begin
        if (owed == 3'd0) begin
          state_nx = IDLE;
        end else if (owed >= 3'd2 && DimeCount != 4'd0) begin
          sel_dime_nx = 1'b1;
          state_nx    = COIN;
        end else if (NickelCount != 4'd0) begin
          sel_dime_nx = 1'b0;
          state_nx    = COIN;
        end else begin
          err_set  = 1'b1;
          state_nx = IDLE;
        end
      end
      COIN: begin
        EjectDime   = sel_dime;
        EjectNickel = ~sel_dime;
        if (MechDone) begin
          coin_take = 1'b1;
          owed_nx   = owed - (sel_dime ? 3'd2 : 3'd1);
          state_nx  = GAP;
        end
      end
      GAP:     state_nx = SELECT;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      owed        <= 3'd0;
      sel_dime    <= 1'b0;
      Overrun     <= 1'b0;
      ChangeError <= 1'b0;
      Shortfall   <= 3'd0;
    end else begin
      state    <= state_nx;
      owed     <= owed_nx;
      sel_dime <= sel_dime_nx;
      Overrun  <= Dispense & Busy;
      if (err_set) begin
        ChangeError <= 1'b1;
        Shortfall   <= owed;
      end
    end
  end

  // A refill and a payout on the same edge cancel out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      NickelCount <= INIT_N;
      DimeCount   <= INIT_D;
    end else begin
      case ({LoadNickel, nick_dec})
        2'b10:   if (NickelCount != 4'd15) NickelCount <= NickelCount + 4'd1;
        2'b01:   NickelCount <= NickelCount - 4'd1;
        default: ;
      endcase
      case ({LoadDime, dime_dec})
        2'b10:   if (DimeCount != 4'd15) DimeCount <= DimeCount + 4'd1;
        2'b01:   DimeCount <= DimeCount - 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser. Instance a uses the default inventory
// (10/10). Instance b starts at 1 nickel and 0 dimes, which sets up the
// dime-shortage and error cases. Both instances share the same inputs.
module tb_change_dispenser;

  logic clk = 1'b0;
  logic reset;
  logic Dispense, ReturnNickel, ReturnDime, ReturnTwoDimes, MechDone;
  logic LoadNickel, LoadDime;

  logic a_ep, a_en, a_ed, a_busy, a_ovr, a_err;
  logic [2:0] a_sf;
  logic [3:0] a_nc, a_dc;
  logic b_ep, b_en, b_ed, b_busy, b_ovr, b_err;
  logic [2:0] b_sf;
  logic [3:0] b_nc, b_dc;

  change_dispenser dut_a (
    .clk(clk), .reset(reset), .Dispense(Dispense), .ReturnNickel(ReturnNickel),
    .ReturnDime(ReturnDime), .ReturnTwoDimes(ReturnTwoDimes), .MechDone(MechDone),
    .LoadNickel(LoadNickel), .LoadDime(LoadDime),
    .EjectProduct(a_ep), .EjectNickel(a_en), .EjectDime(a_ed), .Busy(a_busy),
    .Overrun(a_ovr), .ChangeError(a_err), .Shortfall(a_sf),
    .NickelCount(a_nc), .DimeCount(a_dc)
  );

  change_dispenser #(.INIT_NICKELS(1), .INIT_DIMES(0)) dut_b (
    .clk(clk), .reset(reset), .Dispense(Dispense), .ReturnNickel(ReturnNickel),
    .ReturnDime(ReturnDime), .ReturnTwoDimes(ReturnTwoDimes), .MechDone(MechDone),
    .LoadNickel(LoadNickel), .LoadDime(LoadDime),
    .EjectProduct(b_ep), .EjectNickel(b_en), .EjectDime(b_ed), .Busy(b_busy),
    .Overrun(b_ovr), .ChangeError(b_err), .Shortfall(b_sf),
    .NickelCount(b_nc), .DimeCount(b_dc)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  int total = 0;
  int bad = 0;
  int a_hs_p = 0, a_hs_n = 0, a_hs_d = 0;
  int b_hs_n = 0, b_hs_d = 0;
  int multi_err = 0;
  logic [1:0] exp_q[$];   // 1=product, 2=nickel, 3=dime
  logic [1:0] obs_q[$];

  // handshake monitor: an ejection completes when MechDone meets a high Eject*
  always @(posedge clk) begin
    if (!reset) begin
      if (MechDone && a_ep) begin a_hs_p++; obs_q.push_back(2'd1); end
      if (MechDone && a_en) begin a_hs_n++; obs_q.push_back(2'd2); end
      if (MechDone && a_ed) begin a_hs_d++; obs_q.push_back(2'd3); end
      if (MechDone && b_en) b_hs_n++;
      if (MechDone && b_ed) b_hs_d++;
    end
  end

  always @(negedge clk) begin
    if ((int'(a_ep) + int'(a_en) + int'(a_ed)) > 1) multi_err++;
    if ((int'(b_ep) + int'(b_en) + int'(b_ed)) > 1) multi_err++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    Dispense = 0; ReturnNickel = 0; ReturnDime = 0; ReturnTwoDimes = 0;
    MechDone = 0; LoadNickel = 0; LoadDime = 0;
  endtask

  task automatic run_b_until_idle(input string tag);
    for (int i = 0; i < 40 && b_busy; i++) step();
    MechDone = 0;
    check(tag, b_busy, 0);
  endtask

  int base_n, base_d;

  initial begin
    clear_inputs();
    reset = 0;
    #1 reset = 1;
    #1;
    // reset values, seen immediately on assertion
    check("rst_busy", a_busy, 0);
    check("rst_ejects", {a_ep, a_en, a_ed}, 0);
    check("rst_ovr", a_ovr, 0);
    check("rst_err", a_err, 0);
    check("rst_sf", a_sf, 0);
    check("rst_nc", a_nc, 10);
    check("rst_dc", a_dc, 10);
    check("rst_b_nc", b_nc, 1);
    check("rst_b_dc", b_dc, 0);
    step(); step();
    reset = 0;
    step();

    // Return inputs without Dispense are ignored
    ReturnDime = 1; ReturnNickel = 1;
    step();
    ReturnDime = 0; ReturnNickel = 0;
    check("ret_only_busy", a_busy, 0);

    // product only, three cycles of EjectProduct
    Dispense = 1;
    check("lat_before", a_ep, 0);
    step();
    Dispense = 0;
    check("lat_ep_c1", a_ep, 1);
    check("lat_busy_c1", a_busy, 1);
    step();
    check("vend_ep_c2", a_ep, 1);
    step();
    check("vend_ep_c3", a_ep, 1);
    MechDone = 1;
    step();
    MechDone = 0;
    check("vend_sel_ejects", {a_ep, a_en, a_ed}, 0);
    check("vend_sel_busy", a_busy, 1);
    step();
    check("vend_idle", a_busy, 0);
    check("vend_nc", a_nc, 10);
    check("vend_dc", a_dc, 10);
    check("vend_coins", a_hs_n + a_hs_d, 0);
    check("vend_products", a_hs_p, 1);

    // 15c change: product, dime, nickel
    obs_q.delete();
    exp_q = '{2'd1, 2'd3, 2'd2};
    Dispense = 1; ReturnNickel = 1; ReturnDime = 1;
    step();
    Dispense = 0; ReturnNickel = 0; ReturnDime = 0;
    check("c15_ep", a_ep, 1);
    MechDone = 1;
    step();
    MechDone = 0;
    check("c15_sel_ejects", {a_ep, a_en, a_ed}, 0);
    step();
    check("c15_coin_dime", {a_en, a_ed}, 2'b01);
    MechDone = 1;
    step();
    check("c15_gap_ejects", {a_ep, a_en, a_ed}, 0);
    check("c15_gap_dc", a_dc, 9);
    step();  // MechDone still high through GAP and into SELECT
    check("c15_sel2_ejects", {a_ep, a_en, a_ed}, 0);
    check("c15_sel2_counts", {a_nc, a_dc}, {4'd10, 4'd9});
    MechDone = 0;
    step();
    check("c15_coin_nick", {a_en, a_ed}, 2'b10);
    step();
    check("c15_coin_nick_hold", {a_en, a_ed}, 2'b10);
    MechDone = 1;
    step();
    MechDone = 0;
    check("c15_gap2_nc", a_nc, 9);
    step(); step();
    check("c15_idle", a_busy, 0);
    check("c15_nc", a_nc, 9);
    check("c15_dc", a_dc, 9);
    check("c15_q_len", obs_q.size(), exp_q.size());
    for (int i = 0; i < 3 && i < obs_q.size(); i++) check("c15_q_item", obs_q[i], exp_q[i]);

    // Dispense during VEND is dropped with a one-cycle Overrun
    Dispense = 1;
    step();
    check("ovr_accept", a_ovr, 0);
    step();
    Dispense = 0;
    check("ovr_pulse", a_ovr, 1);
    check("ovr_ep", a_ep, 1);
    step();
    check("ovr_clear", a_ovr, 0);
    MechDone = 1;
    step();
    MechDone = 0;
    step(); step(); step();
    check("ovr_idle", a_busy, 0);
    check("ovr_products", a_hs_p, 3);

    // refill and nickel payout on the same edge leave the count unchanged
    Dispense = 1; ReturnNickel = 1;
    step();
    Dispense = 0; ReturnNickel = 0;
    MechDone = 1;
    step();
    MechDone = 0;
    step();
    check("ld_coin_nick", a_en, 1);
    MechDone = 1; LoadNickel = 1;
    step();
    MechDone = 0; LoadNickel = 0;
    check("ld_dec_nc", a_nc, 9);
    step(); step();
    check("ld_idle", a_busy, 0);

    // refill saturates at 15
    LoadNickel = 1;
    repeat (8) step();
    LoadNickel = 0;
    check("sat_nc", a_nc, 15);
    LoadDime = 1;
    step();
    LoadDime = 0;
    check("ld_dc", a_dc, 10);

    // reset during a dime ejection
    Dispense = 1; ReturnDime = 1;
    step();
    Dispense = 0; ReturnDime = 0;
    MechDone = 1;
    step();
    MechDone = 0;
    step();
    check("rst_mid_dime", a_ed, 1);
    #2 reset = 1;
    #1;
    check("rst_mid_ed_async", a_ed, 0);
    check("rst_mid_busy", a_busy, 0);
    check("rst_mid_counts", {a_nc, a_dc}, {4'd10, 4'd10});
    check("rst_mid_err", a_err, 0);
    step();
    reset = 0;
    step();

    // no dimes: 20c paid as four nickels
    LoadNickel = 1;
    repeat (9) step();
    LoadNickel = 0;
    check("nd_pre_counts", {b_nc, b_dc}, {4'd10, 4'd0});
    base_n = b_hs_n; base_d = b_hs_d;
    Dispense = 1; ReturnTwoDimes = 1;
    step();
    Dispense = 0; ReturnTwoDimes = 0;
    MechDone = 1;
    run_b_until_idle("nd_timeout");
    check("nd_nickels", b_hs_n - base_n, 4);
    check("nd_dimes", b_hs_d - base_d, 0);
    check("nd_nc", b_nc, 6);
    check("nd_err", b_err, 0);

    // one nickel, no dimes, 10c owed: short by one nickel
    reset = 1;
    step();
    reset = 0;
    step();
    base_n = b_hs_n;
    Dispense = 1; ReturnDime = 1;
    step();
    Dispense = 0; ReturnDime = 0;
    MechDone = 1;
    run_b_until_idle("short_timeout");
    check("short_nickels", b_hs_n - base_n, 1);
    check("short_err", b_err, 1);
    check("short_sf", b_sf, 1);
    check("short_nc", b_nc, 0);

    // a later error keeps ChangeError set and replaces Shortfall
    Dispense = 1; ReturnNickel = 1; ReturnTwoDimes = 1;
    step();
    Dispense = 0; ReturnNickel = 0; ReturnTwoDimes = 0;
    MechDone = 1;
    run_b_until_idle("short2_timeout");
    check("short2_err", b_err, 1);
    check("short2_sf", b_sf, 5);

    check("one_hot_ejects", multi_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
